// File: rtl/switch_bank_ctrl.sv
// switch_bank_ctrl
//   Conditions NUM_BANKS banks of 8 DIP switches. Each bank passes through a
//   two-flop synchroniser and a per-bank debounce filter. The debounced values
//   are exposed as read-only bus words. A write-1-to-clear change-pending
//   register and an interrupt mask register drive one level interrupt line.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   dip_in     in   raw switch pins, bank b = dip_in[8b+7:8b]
//   addr       in   bus byte address
//   we         in   bus write strobe, sampled on the rising edge of clk
//   wdata      in   bus write data
//   switch_rd  out  combinational read data for addr
//   switch_int out  registered level interrupt = |(pending & mask)
//
// Address map (k = (addr - BASE_ADDR) >> 2, NW = ceil(NUM_BANKS/4))
//   k = 0..NW-1  DATA words, read-only, four banks per word
//   k = NW       PENDING, write 1 to clear
//   k = NW+1     MASK, read/write
//   other        reads 32'h1723fffe, writes ignored
//
// Build option
//   SWITCH_DEBOUNCE_BYPASS_EN : when defined the debounce counters are not
//   built; stable follows the synchroniser output every edge.

module switch_bank_ctrl #(
  parameter int          NUM_BANKS       = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h00007f2c,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_BANKS-1:0] dip_in,
  input  logic [31:0]            addr,
  input  logic                   we,
  input  logic [31:0]            wdata,
  output logic [31:0]            switch_rd,
  output logic                   switch_int
);

  localparam int          W      = 8 * NUM_BANKS;
  localparam int          NW     = (NUM_BANKS + 3) / 4;
  localparam logic [29:0] K_PEND = 30'(NW);
  localparam logic [29:0] K_MASK = 30'(NW + 1);
  localparam logic [31:0] BAD_RD = 32'h1723fffe;

  logic [W-1:0]         logical_in;
  logic [W-1:0]         sync1_q, sync2_q;
  logic [W-1:0]         stable_q, stable_d;
  logic [NUM_BANKS-1:0] pend_q, pend_d;
  logic [NUM_BANKS-1:0] mask_q, mask_d;
  logic [NUM_BANKS-1:0] set_b, clr_b;
  logic                 int_q;

  // Decode signals
  logic [31:0]   off;
  logic [29:0]   k;
  logic          addr_ok, is_data, is_pend, is_mask;
  logic [NW*32-1:0] data_pad;
  logic          unused_wdata;

  assign logical_in   = ACTIVE_LOW ? ~dip_in : dip_in;
  assign unused_wdata = ^wdata;

  // Addresses below the base wrap to a huge offset; reject them explicitly.
  assign off     = addr - BASE_ADDR;
  assign k       = off[31:2];
  assign addr_ok = (addr >= BASE_ADDR) && (off[1:0] == 2'b00);
  assign is_data = addr_ok && (k < K_PEND);
  assign is_pend = addr_ok && (k == K_PEND);
  assign is_mask = addr_ok && (k == K_MASK);

`ifdef SWITCH_DEBOUNCE_BYPASS_EN
  always_comb begin
    stable_d = sync2_q;
    set_b    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      set_b[b] = (sync2_q[8*b +: 8] != stable_q[8*b +: 8]);
    end
  end
`else
  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [NUM_BANKS];
  logic [CNT_W-1:0] cnt_d [NUM_BANKS];

  // A bounce back to the stable value restarts the count; a change to a
  // different non-stable value keeps counting and the value present on the
  // accepting edge is the one taken.
  always_comb begin
    stable_d = stable_q;
    set_b    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      cnt_d[b] = cnt_q[b];
      if (sync2_q[8*b +: 8] == stable_q[8*b +: 8]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_MAX) begin
        stable_d[8*b +: 8] = sync2_q[8*b +: 8];
        cnt_d[b]           = '0;
        set_b[b]           = 1'b1;
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) cnt_q[b] <= cnt_d[b];
    end
  end
`endif

  // Acceptance wins over a simultaneous W1C clear of the same bit.
  always_comb begin
    clr_b  = (we && is_pend) ? wdata[NUM_BANKS-1:0] : '0;
    pend_d = (pend_q & ~clr_b) | set_b;
    mask_d = (we && is_mask) ? wdata[NUM_BANKS-1:0] : mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      int_q    <= 1'b0;
    end else begin
      sync1_q  <= logical_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      // Uses the pre-edge mask and pending, so a mask write shows one edge later.
      int_q    <= |(pend_q & mask_q);
    end
  end

  assign switch_int = int_q;

  // Read mux; banks beyond NUM_BANKS in the last data word read 0.
  always_comb begin
    data_pad          = '0;
    data_pad[W-1:0]   = stable_q;
    switch_rd         = BAD_RD;
    if (is_data) begin
      switch_rd = '0;
      for (int i = 0; i < NW; i++) begin
        if (k == 30'(i)) switch_rd = data_pad[32*i +: 32];
      end
    end else if (is_pend) begin
      switch_rd                  = '0;
      switch_rd[NUM_BANKS-1:0]   = pend_q;
    end else if (is_mask) begin
      switch_rd                  = '0;
      switch_rd[NUM_BANKS-1:0]   = mask_q;
    end
  end

endmodule
